mult_seq_param: RTL and testbench
=================================

Name: mult_seq_param

Overview:
- Parametrised sequential shift-add multiplier.
- Successor to the fixed 8-bit multiplier: configurable operand width, a signed/unsigned mode per operation, and valid/ready handshakes on both input and output.
- Sits between an operand producer and a result consumer in the datapath.
- One product is in flight at a time.

Parameters:
- WIDTH, 8: operand width in bits, must be at least 2. The product z is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1): width of the iteration counter. Derived; do not override.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  operands x, y and is_signed are presented.
- in_ready  output  1  block can accept operands.
- x  input  WIDTH  multiplicand.
- y  input  WIDTH  multiplier.
- is_signed  input  1  1 = two's-complement operands; 0 = unsigned.
- out_valid  output  1  z holds a completed product.
- out_ready  input  1  consumer accepts z.
- z  output  2*WIDTH  product.
- busy  output  1  high in BUSY state.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state goes to IDLE.
  - z=0, out_valid=0, busy=0, in_ready=1, counter=0, accumulator=0.
  - Reset takes priority over every other event, including mid-operation; a partial product is discarded, never emitted.
- State machine: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge, capture operands.
    - Unsigned mode: magnitudes are x and y as given.
    - Signed mode: magnitudes are |x| and |y|. The sign flag is x[MSB] xor y[MSB].
    - The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits in WIDTH unsigned bits, with no overflow.
  - Clear the accumulator and counter, then go to BUSY.
- BUSY:
  - in_ready=0. in_valid is ignored and x/y/is_signed are not sampled.
  - Each cycle: if the multiplier LSB is 1, add (multiplicand << counter) into the 2*WIDTH-bit accumulator.
  - Then shift the multiplier right by 1 and increment the counter.
  - After WIDTH iterations, write z = sign ? -acc : acc, modulo 2^(2*WIDTH). Set out_valid=1 and go to DONE.
- Latency: operands accepted at edge 0 produce out_valid=1 after edge WIDTH, i.e. WIDTH cycles. This is fixed and independent of operand values unless the optional feature is enabled.
- DONE:
  - out_valid=1, in_ready=0.
  - z is held stable while out_valid && !out_ready, for any number of cycles.
  - On out_ready: out_valid=0, go to IDLE. z keeps its last value.
  - A new operand is accepted no earlier than the cycle after the handshake.
- Width rules:
  - The signed product of two WIDTH-bit operands always fits in 2*WIDTH bits.
  - The unsigned maximum (2^WIDTH-1)^2 fits as well.
- Zero operands follow the normal flow with the normal latency and return z=0 (negative zero is impossible).

Optional Feature:
- Macro: MULT_SEQ_EARLY_TERM_EN.
- Defined:
  - In BUSY, when the remaining shifted multiplier is zero after an iteration, finish immediately: sign-correct, write z, go to DONE.
  - Latency becomes max(1, index of highest set bit of |y| + 1) cycles.
  - y=0 completes in 1 cycle.
- Undefined:
  - Latency is always exactly WIDTH cycles.
  - No zero-detect logic is synthesised.

Decomposition:
- Package mult_seq_pkg holds:
  - state_t, an enum of IDLE, BUSY, DONE.
  - A helper function abs_val(value, is_signed) returning an unsigned magnitude.
- One natural sub-module: mult_seq_datapath.
  - Contains the accumulator, shift registers and counter.
  - Control comes from the FSM in mult_seq_param.

Test Plan (WIDTH=8 unless noted):
- Reset, then unsigned 5*5 -> out_valid after exactly 8 cycles, z=16'd25. Then 1*1 -> z=1. Then 2*3 -> z=6.
- Unsigned 255*255 -> z=16'hFE01 (65025). Signed -128*-128 -> z=16'h4000. Signed -3*5 -> z=16'hFFF1. Signed 127*-128 -> z=16'hC080.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> z stable, in_ready=0, and in_valid pulses are ignored (no second product). Release -> one handshake, then IDLE.
- Reset mid-operation: drive rst=0 for one edge at iteration 4 of 7*9 -> out_valid never rises, state IDLE, z=0. Next 7*9 -> z=63 in 8 cycles.
- Back-to-back: in_valid held high continuously with out_ready=1 -> each accept is spaced WIDTH+2 cycles apart, all products correct. Also run WIDTH=16: 16'hFFFF*16'hFFFF unsigned -> 32'hFFFE0001.
- With MULT_SEQ_EARLY_TERM_EN: y=1 -> 1-cycle latency. y=0 -> 1 cycle, z=0. y=8'h80 -> 8 cycles. Results match the non-early-termination build.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// The magnitude helper works on a 64-bit container so any WIDTH up to 64 can use it.
package mult_seq_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Caller sign- or zero-extends the operand into MAX_W bits; the magnitude of the
    // most negative WIDTH-bit value then fits in WIDTH unsigned bits after truncation.
    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] value,
                                                 input logic             is_signed);
        logic [MAX_W-1:0] mag;
        mag = value;
        if (is_signed && value[MAX_W-1]) begin
            mag = ~value + MAX_W'(1);
        end
        return mag;
    endfunction

endpackage

// File: rtl/mult_seq_datapath.sv
// Accumulator, multiplicand/multiplier registers and iteration counter of the multiplier.
// Build option MULT_SEQ_EARLY_TERM_EN finishes as soon as the remaining multiplier is zero.
module mult_seq_datapath
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               is_signed,
    output logic               last,
    output logic [2*WIDTH-1:0] z
);

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   shifted;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] z_next;
    logic [WIDTH-1:0]   x_mag;
    logic [WIDTH-1:0]   y_mag;
    logic               sign;

    always_comb begin
        x_mag = WIDTH'(abs_val(is_signed ? MAX_W'(signed'(x)) : MAX_W'(x), is_signed));
        y_mag = WIDTH'(abs_val(is_signed ? MAX_W'(signed'(y)) : MAX_W'(y), is_signed));
    end

    // One iteration: conditionally add the multiplicand weighted by the bit position.
    always_comb begin
        partial  = {{WIDTH{1'b0}}, mcand} << cnt;
        acc_next = mplier[0] ? (acc + partial) : acc;
        shifted  = mplier >> 1;
        z_next   = sign ? (~acc_next + (2*WIDTH)'(1)) : acc_next;
    end

`ifdef MULT_SEQ_EARLY_TERM_EN
    assign last = (shifted == '0);
`else
    assign last = (cnt == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            acc    <= '0;
            sign   <= 1'b0;
            z      <= '0;
        end else if (load) begin
            mcand  <= x_mag;
            mplier <= y_mag;
            sign   <= is_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
            cnt    <= '0;
            acc    <= '0;
        end else if (step) begin
            acc    <= acc_next;
            mplier <= shifted;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                z <= z_next;
            end
        end
    end

endmodule

// File: rtl/mult_seq_param.sv
// Sequential shift-add multiplier with valid/ready on both sides, one product in flight.
// Build option MULT_SEQ_EARLY_TERM_EN enables data-dependent early completion.
module mult_seq_param
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] z,
    output logic               busy
);

    state_t state;
    logic   load;
    logic   step;
    logic   last;

    assign load = (state == IDLE) && in_valid;
    assign step = (state == BUSY);

    mult_seq_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .x         (x),
        .y         (y),
        .is_signed (is_signed),
        .last      (last),
        .z         (z)
    );

    // Handshake outputs are registered alongside the state so they never glitch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    if (last) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_param.sv
// Scoreboard bench for mult_seq_param: 8-bit instance for the main flow, 16-bit instance
// for the wide corner. Latency expectations follow MULT_SEQ_EARLY_TERM_EN when defined.
module tb_mult_seq_param;

`ifdef MULT_SEQ_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, is_signed, out_valid, out_ready, busy;
    logic [7:0]  x, y;
    logic [15:0] z;
    logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
    logic [15:0] x16, y16;
    logic [31:0] z16;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] expq[$];
    int          latq[$];

    always #5 clk = ~clk;

    mult_seq_param #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .z(z), .busy(busy)
    );

    mult_seq_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .x(x16), .y(y16), .is_signed(1'b0), .out_valid(out_valid16),
        .out_ready(out_ready16), .z(z16), .busy(busy16)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic s);
        int p;
        if (s) p = int'($signed(a)) * int'($signed(b));
        else   p = int'(a) * int'(b);
        return p[15:0];
    endfunction

    function automatic int expLat(input logic [7:0] b, input logic s);
        int m;
        int l;
        m = (s && b[7]) ? (256 - int'(b)) : int'(b);
        l = 1;
        for (int i = 0; i < 8; i++) if (m[i]) l = i + 1;
        return EARLY ? l : 8;
    endfunction

    // Called one time unit after a rising edge with the DUT idle.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic s, input int hold);
        int          n;
        logic [15:0] held;
        x = a; y = b; is_signed = s; in_valid = 1'b1;
        expq.push_back(model(a, b, s));
        latq.push_back(expLat(b, s));
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("acceptBusy", busy, 1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("latency", n, latq.pop_front());
        checkOutput("product", z, expq.pop_front());
        held = z;
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            x = 8'h11; y = 8'h22;
            @(posedge clk); #1;
            checkOutput("holdZ", z, held);
            checkOutput("holdValid", out_valid, 1);
            checkOutput("holdReady", in_ready, 0);
            checkOutput("holdBusy", busy, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("afterValid", out_valid, 0);
        checkOutput("afterReady", in_ready, 1);
        checkOutput("afterZ", z, held);
    endtask

    logic [7:0] bxa[5] = '{8'd3, 8'hFF, 8'd0, 8'h81, 8'd12};
    logic [7:0] bya[5] = '{8'd4, 8'h02, 8'd9, 8'h7F, 8'h40};
    logic       bsa[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int   n;
        int   idx;
        int   prevAcc;
        int   prevLat;
        logic sawValid;

        rst = 1'b0;
        in_valid = 1'b0; x = '0; y = '0; is_signed = 1'b0; out_ready = 1'b0;
        in_valid16 = 1'b0; x16 = '0; y16 = '0; out_ready16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstZ", z, 0);
        checkOutput("rstValid", out_valid, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstReady", in_ready, 1);
        checkOutput("rstReady16", in_ready16, 1);
        rst = 1'b1;
        @(posedge clk); #1;

        applyStimulus(8'd5,   8'd5,   1'b0, 0);
        applyStimulus(8'd1,   8'd1,   1'b0, 0);
        applyStimulus(8'd2,   8'd3,   1'b0, 0);
        applyStimulus(8'hFF,  8'hFF,  1'b0, 0);
        applyStimulus(8'h80,  8'h80,  1'b1, 0);
        applyStimulus(8'hFD,  8'd5,   1'b1, 0);
        applyStimulus(8'd127, 8'h80,  1'b1, 0);
        applyStimulus(8'hFB,  8'd0,   1'b1, 0);
        applyStimulus(8'd0,   8'd0,   1'b0, 0);
        applyStimulus(8'd77,  8'd1,   1'b0, 0);
        applyStimulus(8'd3,   8'h80,  1'b0, 0);
        applyStimulus(8'd200, 8'd3,   1'b0, 10);

        // Reset lands on the fourth iteration of 7*9; the product must vanish.
        x = 8'd7; y = 8'd9; is_signed = 1'b0; in_valid = 1'b1;
        expq.push_back(model(8'd7, 8'd9, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        expq.delete();
        checkOutput("midRstReady", in_ready, 1);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstZ", z, 0);
        sawValid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            sawValid |= out_valid;
            @(posedge clk); #1;
        end
        checkOutput("midRstNoValid", sawValid, 0);
        applyStimulus(8'd7, 8'd9, 1'b0, 0);

        // in_valid stays high except when the table is exhausted; consumer always ready.
        idx = 0; prevAcc = -1; prevLat = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && (idx < 5 || expq.size() > 0); cyc++) begin
            if (out_valid) checkOutput("b2bZ", z, expq.pop_front());
            if (in_ready) begin
                if (idx < 5) begin
                    if (prevAcc >= 0) checkOutput("b2bSpacing", cyc - prevAcc, prevLat + 2);
                    x = bxa[idx]; y = bya[idx]; is_signed = bsa[idx];
                    in_valid = 1'b1;
                    expq.push_back(model(bxa[idx], bya[idx], bsa[idx]));
                    prevLat = expLat(bya[idx], bsa[idx]);
                    prevAcc = cyc;
                    idx++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checkOutput("b2bCount", idx, 5);

        x16 = 16'hFFFF; y16 = 16'hFFFF; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        n = 0;
        while (!out_valid16 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("w16Latency", n, 16);
        checkOutput("w16Product", z16, 32'hFFFE0001);
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
        checkOutput("w16Ready", in_ready16, 1);

        checkOutput("sbEmpty", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
